// File: rtl/fifo_512_60bit_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_512_60bit_rd_stream
//
// Read-side drain engine for the 512x60 FIFO. It issues FIFO reads, absorbs
// the one-cycle RAM read latency in a small skid buffer, and presents the
// words to a downstream consumer as a valid/ready stream at up to 1 word/cycle.
//
// Parameters
//   DW     data width, must match the FIFO word width
//   DEPTH  skid-buffer entries (2..4); 2 is the minimum for full throughput
//
// Ports
//   clk         in   clock, all logic on posedge
//   resetn      in   synchronous active-low reset
//   flush       in   drop buffered and in-flight words (pulse with FIFO clr)
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_re=1
//   fifo_re     out  FIFO read enable (combinational)
//   out_valid   out  out_data holds a valid word
//   out_ready   in   consumer accepts; transfer on out_valid & out_ready
//   out_data    out  head word of the skid buffer (0 while empty)
//   word_cnt    out  [31:0] delivered-word counter, only when the build
//                    defines FIFO_RD_WORDCNT_EN
//
// Build option
//   FIFO_RD_WORDCNT_EN  adds word_cnt: +1 per pop, wraps, cleared by reset
//                       and flush (a pop in the flush cycle is not counted).
// -----------------------------------------------------------------------------
module fifo_512_60bit_rd_stream #(
  parameter int DW    = 60,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_re,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef FIFO_RD_WORDCNT_EN
  output logic [31:0]   word_cnt,
`endif
  output logic [DW-1:0] out_data
);

  // Pointer width; count width must also hold count+inf (up to DEPTH+1).
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 2);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] wp_q, wp_d;
  logic          inf_q, inf_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic          pop;
  logic          cap;
  logic [CW-1:0] credit;

  // Circular-buffer pointer advance with explicit wrap (DEPTH need not be 2^n).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rp_q] : '0;
  assign pop       = out_valid & out_ready;
  assign cap       = inf_q;

  // Slots committed after this edge: held words plus the one in flight, minus
  // the word leaving now. Counting the same-cycle pop keeps a full buffer that
  // drains at 1/cycle reading every cycle.
  assign credit  = count_q + CW'(inf_q) - CW'(pop);
  assign fifo_re = resetn & ~flush & ~fifo_empty & (credit < DEPTH_C);

  always_comb begin
    count_d = count_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    inf_d   = inf_q;
    mem_d   = mem_q;
    if (flush) begin
      // Flush wins over capture and pop; the word on fifo_dout is dropped.
      count_d = '0;
      rp_d    = '0;
      wp_d    = '0;
      inf_d   = 1'b0;
    end else begin
      inf_d = fifo_re;
      if (cap) begin
        mem_d[wp_q] = fifo_dout;
        wp_d        = ptr_inc(wp_q);
      end
      if (pop) begin
        rp_d = ptr_inc(rp_q);
      end
      count_d = count_q + CW'(cap) - CW'(pop);
    end
  end

  // Control state: reset applies here only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
      rp_q    <= '0;
      wp_q    <= '0;
      inf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      inf_q   <= inf_d;
    end
  end

  // Data storage: not reset; out_data is masked to 0 while the buffer is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef FIFO_RD_WORDCNT_EN
  logic [31:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (flush) begin
      word_cnt_d = '0;
    end else if (pop) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_512_60bit_rd_stream.sv
module tb_fifo_512_60bit_rd_stream;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        fifo_empty;
  logic [59:0] fifo_dout;
  logic        fifo_re;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] out_data;
`ifdef FIFO_RD_WORDCNT_EN
  logic [31:0] word_cnt;
`endif

  fifo_512_60bit_rd_stream #(.DW(60), .DEPTH(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_re   (fifo_re),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FIFO_RD_WORDCNT_EN
    .word_cnt  (word_cnt),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model contents, and the scoreboard of words read from it
  // that the consumer has yet to receive (in order).
  logic [59:0] fq [$];
  logic [59:0] exp_q [$];
  int          checks;
  int          failures;
  int          delivered;
  logic [59:0] last_data;
  logic        re_s;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [59:0] rnd60();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[59:0];
  endfunction

  task automatic push(input logic [59:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Advance one clock; model the FIFO RAM: a read at this edge shows the
  // popped word on fifo_dout for the following cycle, otherwise garbage.
  task automatic tick();
    @(posedge clk);
    #1;
    if (re_s && fq.size() != 0) begin
      fifo_dout = fq.pop_front();
      exp_q.push_back(fifo_dout);
    end else begin
      fifo_dout = rnd60();
    end
    fifo_empty = (fq.size() == 0);
  endtask

  // Monitor: scoreboard compare on every handshake, read-enable legality.
  always @(negedge clk) begin
    if (resetn && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%0h want=none", out_data);
      end else begin
        chk("stream_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
      delivered++;
      last_data = out_data;
    end
    if (resetn && fifo_re) chk("re_while_empty", 64'(fifo_empty), 64'(0));
    re_s <= fifo_re;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int nre;
    int nw;
    int guard;
    clk = 0; resetn = 0; flush = 0; out_ready = 0;
    fifo_dout = '0; fifo_empty = 1; re_s = 0;
    checks = 0; failures = 0; delivered = 0; last_data = '0;

    // Reset with a non-empty FIFO
    for (int i = 1; i <= 16; i++) push(60'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_re", 64'(fifo_re), 64'(0));
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      tick();
    end

    // Streaming: first word 2 cycles after reset release, then 16 back-to-back
    out_ready = 1; resetn = 1;
    @(negedge clk); chk("lat_c0", 64'(out_valid), 64'(0));
    tick();
    @(negedge clk); chk("lat_c1", 64'(out_valid), 64'(0));
    tick();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); chk("stream_valid", 64'(out_valid), 64'(1));
      tick();
    end
    @(negedge clk);
    chk("stream_end_valid", 64'(out_valid), 64'(0));
    chk("stream_count", 64'(delivered), 64'(16));
    chk("stream_last", 64'(last_data), 64'(16));
    tick();

    // Backpressure: only DEPTH reads, head held stable
    out_ready = 0;
    d0 = delivered;
    for (int i = 1; i <= 8; i++) push(60'(i));
    nre = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (fifo_re) nre++;
      tick();
    end
    chk("bp_re_pulses", 64'(nre), 64'(2));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_hold", 64'(out_data), 64'(1));
      tick();
    end
    out_ready = 1;
    guard = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && guard < 100) begin
      tick(); guard++;
    end
    chk("bp_timeout", 64'(guard < 100), 64'(1));
    chk("bp_count", 64'(delivered - d0), 64'(8));
    chk("bp_last", 64'(last_data), 64'(8));
    chk("bp_fifo_empty", 64'(fq.size()), 64'(0));

    // Random writes and random stalls, 512 words
    d0 = delivered; nw = 0; guard = 0;
    while ((nw < 512 || fq.size() != 0 || exp_q.size() != 0) && guard < 20000) begin
      if (nw < 512 && $urandom_range(0, 1) == 1) begin
        push(rnd60()); nw++;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      tick(); guard++;
    end
    out_ready = 1;
    repeat (4) tick();
    chk("rnd_timeout", 64'(guard < 20000), 64'(1));
    chk("rnd_count", 64'(delivered - d0), 64'(512));

    // Flush with one buffered word and one in flight
    out_ready = 0;
    for (int i = 0; i < 4; i++) push(60'(32'h100 + i));
    repeat (5) tick();
    @(negedge clk); chk("fl_pre_valid", 64'(out_valid), 64'(1));
    out_ready = 1;
    tick();
    out_ready = 0; flush = 1;
    fq.delete(); fifo_empty = 1;
    @(negedge clk); chk("fl_re", 64'(fifo_re), 64'(0));
    tick();
    exp_q.delete();
    flush = 0;
    @(negedge clk);
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_data", 64'(out_data), 64'(0));
    d0 = delivered;
    push(60'h ABC);
    out_ready = 1;
    guard = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && guard < 50) begin
      tick(); guard++;
    end
    repeat (3) tick();
    chk("fl_timeout", 64'(guard < 50), 64'(1));
    chk("fl_count", 64'(delivered - d0), 64'(1));
    chk("fl_first", 64'(last_data), 64'(60'h ABC));

`ifdef FIFO_RD_WORDCNT_EN
    out_ready = 0; flush = 1;
    tick();
    flush = 0;
    @(negedge clk); chk("wc_flush0", 64'(word_cnt), 64'(0));
    for (int i = 0; i < 5; i++) push(rnd60());
    out_ready = 1;
    guard = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && guard < 50) begin
      tick(); guard++;
    end
    repeat (2) tick();
    @(negedge clk); chk("wc_five", 64'(word_cnt), 64'(5));
    out_ready = 0; flush = 1;
    tick();
    flush = 0;
    @(negedge clk); chk("wc_flush", 64'(word_cnt), 64'(0));
    push(60'h 55);
    repeat (4) tick();
    force dut.word_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.word_cnt_q;
    chk("wc_preset", 64'(word_cnt), 64'(32'hFFFF_FFFF));
    out_ready = 1;
    tick();
    @(negedge clk); chk("wc_wrap", 64'(word_cnt), 64'(0));
    tick();
    out_ready = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
